cim_tile_model: RTL and testbench

CIM_TILE_MODEL -- requirements
Module: cim_tile_model

---
 rtl/cim_tile_model.sv | 126 ++++++++++++
 tb/tb_cim_tile_model.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_tile_model.sv
// Behavioural model of one compute-in-memory crossbar tile.
// Each operation walks the input buffer one row per cycle. It accumulates the
// activation into every column whose weight bit is set in that row. It then
// quantizes all column sums into the result bank in a single cycle.
module cim_tile_model #(
    parameter int xbar_size     = 512,
    parameter int datatype_size = 2,
    parameter int out_shift     = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_we,
    input  logic [$clog2(xbar_size)-1:0] i_wr_addr,
    input  logic [datatype_size-1:0]     i_wr_data,
    input  logic                         i_start,
    output logic                         o_busy,
    output logic                         o_done,
    input  logic [$clog2(xbar_size)-1:0] i_rd_addr,
    output logic [datatype_size-1:0]     o_data,
    input  logic                         i_wprog_we,
    input  logic [$clog2(xbar_size)-1:0] i_wprog_row,
    input  logic [$clog2(xbar_size)-1:0] i_wprog_col,
    input  logic                         i_wprog_bit
);

    localparam int aw    = $clog2(xbar_size);
    // One extra bit per row doubling: xbar_size * (2**datatype_size - 1) always fits.
    localparam int acc_w = datatype_size + aw;

    localparam logic [aw-1:0]    last_row = aw'(xbar_size - 1);
    localparam logic [acc_w-1:0] sat_max  = {{(acc_w - datatype_size){1'b0}}, {datatype_size{1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        QUANT
    } state_t;

    state_t state, state_nxt;

    logic [aw-1:0]            row;
    logic                     done;
    logic [datatype_size-1:0] in_buf [xbar_size];
    logic [xbar_size-1:0]     w_mem  [xbar_size];
    logic [acc_w-1:0]         acc    [xbar_size];
    logic [datatype_size-1:0] result [xbar_size];

    logic is_idle;

    assign is_idle = (state == IDLE);
    assign o_busy  = !is_idle;
    assign o_done  = done;

    // Shift then clamp a column sum to the largest representable output code.
    function automatic logic [datatype_size-1:0] quantize(input logic [acc_w-1:0] sum);
        logic [acc_w-1:0] shifted;
        // NOTE: inside functions and always_comb, blocking '=' is correct; '<=' is only for clocked state.
        shifted = sum >> out_shift;
        if (shifted > sat_max) return {datatype_size{1'b1}};
        return shifted[datatype_size-1:0];
    endfunction

    // State register.
    // NOTE: clocked state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic: start only from IDLE, walk all rows, one quantize cycle.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = COMPUTE;
            COMPUTE: if (row == last_row) state_nxt = QUANT;
            QUANT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Weight array: single-cell programming, only while the tile is idle.
    // NOTE: the weight memory is deliberately not reset; a reset branch would forbid RAM inference.
    always_ff @(posedge clk) begin
        if (is_idle && i_wprog_we) w_mem[i_wprog_row][i_wprog_col] <= i_wprog_bit;
    end

    // Datapath: input buffer, row walk, accumulation, quantization, registered read port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row    <= '0;
            done   <= 1'b0;
            o_data <= '0;
            for (int i = 0; i < xbar_size; i++) begin
                in_buf[i] <= '0;
                acc[i]    <= '0;
                result[i] <= '0;
            end
        end else begin
            done   <= (state == QUANT);
            o_data <= result[i_rd_addr];
            // Compute reads in_buf from the next cycle onward, so a write alongside start is used.
            if (is_idle && i_we) in_buf[i_wr_addr] <= i_wr_data;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        row <= '0;
                        for (int c = 0; c < xbar_size; c++) acc[c] <= '0;
                    end
                end
                COMPUTE: begin
                    for (int c = 0; c < xbar_size; c++) begin
                        if (w_mem[row][c]) acc[c] <= acc[c] + acc_w'(in_buf[row]);
                    end
                    // Hold on the last row rather than wrapping back to zero.
                    if (row != last_row) row <= row + 1'b1;
                end
                QUANT: begin
                    for (int c = 0; c < xbar_size; c++) result[c] <= quantize(acc[c]);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cim_tile_model.sv
// Directed bench for cim_tile_model at xbar_size=8, datatype_size=2.
// Two tiles share every input; one uses out_shift=0 and the other out_shift=2.
module tb_cim_tile_model;

    localparam int N  = 8;
    localparam int DW = 2;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_we = 1'b0;
    logic [AW-1:0] i_wr_addr = '0;
    logic [DW-1:0] i_wr_data = '0;
    logic          i_start = 1'b0;
    logic [AW-1:0] i_rd_addr = '0;
    logic          i_wprog_we = 1'b0;
    logic [AW-1:0] i_wprog_row = '0;
    logic [AW-1:0] i_wprog_col = '0;
    logic          i_wprog_bit = 1'b0;

    logic          busy0, done0, busy2, done2;
    logic [DW-1:0] data0, data2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cim_tile_model #(.xbar_size(N), .datatype_size(DW), .out_shift(0)) u_dut (
        .clk(clk), .rst(rst), .i_we(i_we), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_start(i_start), .o_busy(busy0), .o_done(done0), .i_rd_addr(i_rd_addr), .o_data(data0),
        .i_wprog_we(i_wprog_we), .i_wprog_row(i_wprog_row), .i_wprog_col(i_wprog_col),
        .i_wprog_bit(i_wprog_bit)
    );

    cim_tile_model #(.xbar_size(N), .datatype_size(DW), .out_shift(2)) u_dut_s2 (
        .clk(clk), .rst(rst), .i_we(i_we), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_start(i_start), .o_busy(busy2), .o_done(done2), .i_rd_addr(i_rd_addr), .o_data(data2),
        .i_wprog_we(i_wprog_we), .i_wprog_row(i_wprog_row), .i_wprog_col(i_wprog_col),
        .i_wprog_bit(i_wprog_bit)
    );

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic wr_in(input int addr, input int val);
        @(negedge clk);
        i_we = 1'b1; i_wr_addr = AW'(addr); i_wr_data = DW'(val);
        @(negedge clk);
        i_we = 1'b0;
    endtask

    task automatic prog(input int r, input int c, input bit b);
        @(negedge clk);
        i_wprog_we = 1'b1; i_wprog_row = AW'(r); i_wprog_col = AW'(c); i_wprog_bit = b;
        @(negedge clk);
        i_wprog_we = 1'b0;
    endtask

    task automatic clear_weights();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) prog(r, c, 1'b0);
    endtask

    // Sets the read address and returns both tiles' o_data one edge later.
    task automatic read_col(input int col, output logic [DW-1:0] d0, output logic [DW-1:0] d2);
        @(negedge clk);
        i_rd_addr = AW'(col);
        @(negedge clk);
        d0 = data0;
        d2 = data2;
    endtask

    // Starts an operation and checks busy length and the done pulse.
    task automatic run_op(input string name);
        int busy_cnt = 0;
        int done_in_busy = 0;
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        while (busy0 && busy_cnt < 40) begin
            busy_cnt++;
            if (done0) done_in_busy++;
            @(negedge clk);
        end
        vectors++;
        if (busy_cnt !== N + 1) begin
            miscompares++;
            $display("FAIL %s busy_len: got %0d expected %0d", name, busy_cnt, N + 1);
        end
        vectors++;
        if (done0 !== 1'b1 || done2 !== 1'b1 || done_in_busy !== 0) begin
            miscompares++;
            $display("FAIL %s done_pulse: got %b/%b (in busy %0d) expected 1/1 (0)", name, done0, done2, done_in_busy);
        end
        @(negedge clk);
        vectors++;
        if (done0 !== 1'b0 || busy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after_done: done %b busy %b expected 0 0", name, done0, busy0);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || data0 !== 2'd0 || data2 !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy %b done %b data %0d/%0d expected 0 0 0/0", busy0, done0, data0, data2);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < N; c += 4) begin
            logic [DW-1:0] d0, d2;
            read_col(c, d0, d2);
            vectors++;
            if (d0 !== 2'd0 || d2 !== 2'd0) begin
                miscompares++;
                $display("FAIL reset_result col%0d: got %0d/%0d expected 0/0", c, d0, d2);
            end
        end
    endtask

    // Column 0 sums to 8 (saturates / shifts to 2), column 2 sums to 3, column 1 is unweighted.
    task automatic test_saturate_shift();
        logic [DW-1:0] d0, d2;
        logic [DW-1:0] exp0 [3] = '{2'd3, 2'd0, 2'd3};
        logic [DW-1:0] exp2 [3] = '{2'd2, 2'd0, 2'd0};
        clear_weights();
        for (int r = 0; r < N; r++) prog(r, 0, 1'b1);
        for (int r = 0; r < 3; r++) prog(r, 2, 1'b1);
        for (int r = 0; r < N; r++) wr_in(r, 1);
        run_op("sat");
        for (int c = 0; c < 3; c++) begin
            read_col(c, d0, d2);
            vectors++;
            if (d0 !== exp0[c] || d2 !== exp2[c]) begin
                miscompares++;
                $display("FAIL sat col%0d: got %0d/%0d expected %0d/%0d", c, d0, d2, exp0[c], exp2[c]);
            end
        end
    endtask

    // Only in[3]=2 and w[3][5]=1: column 5 reads 2, everything else 0.
    task automatic test_single_cell();
        logic [DW-1:0] d0, d2;
        clear_weights();
        prog(3, 5, 1'b1);
        for (int r = 0; r < N; r++) wr_in(r, (r == 3) ? 2 : 0);
        run_op("single");
        for (int c = 0; c < N; c++) begin
            logic [DW-1:0] e0;
            e0 = (c == 5) ? 2'd2 : 2'd0;
            read_col(c, d0, d2);
            vectors++;
            if (d0 !== e0 || d2 !== 2'd0) begin
                miscompares++;
                $display("FAIL single col%0d: got %0d/%0d expected %0d/0", c, d0, d2, e0);
            end
        end
    endtask

    // Second op with in[3]=3; start/write/program at busy cycle 4 must all be ignored.
    task automatic test_back_to_back();
        logic [DW-1:0] d0, d2;
        int busy_cnt = 0;
        int done_in_busy = 0;
        int stale_bad = 0;
        wr_in(3, 3);
        @(negedge clk);
        i_rd_addr = AW'(5);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        while (busy0 && busy_cnt < 40) begin
            busy_cnt++;
            if (done0) done_in_busy++;
            if (data0 !== 2'd2) stale_bad++;
            if (busy_cnt == 4) begin
                i_start = 1'b1; i_we = 1'b1; i_wr_addr = AW'(3); i_wr_data = 2'd1;
                i_wprog_we = 1'b1; i_wprog_row = AW'(3); i_wprog_col = AW'(5); i_wprog_bit = 1'b0;
            end else begin
                i_start = 1'b0; i_we = 1'b0; i_wprog_we = 1'b0;
            end
            @(negedge clk);
        end
        vectors++;
        if (busy_cnt !== N + 1 || done0 !== 1'b1 || done_in_busy !== 0) begin
            miscompares++;
            $display("FAIL b2b busy_len: got %0d done %b expected %0d done 1", busy_cnt, done0, N + 1);
        end
        vectors++;
        if (stale_bad !== 0) begin
            miscompares++;
            $display("FAIL b2b stale_read: got %0d bad cycles expected 0", stale_bad);
        end
        @(negedge clk);
        vectors++;
        if (data0 !== 2'd3 || data2 !== 2'd0) begin
            miscompares++;
            $display("FAIL b2b new_read: got %0d/%0d expected 3/0", data0, data2);
        end
        // A queued start would show busy again here.
        repeat (2) @(negedge clk);
        vectors++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b no_restart: busy %b done %b expected 0 0", busy0, done0);
        end
        // Rerun unchanged: buffer and weight must not have taken the mid-op writes.
        run_op("b2b_rerun");
        read_col(5, d0, d2);
        vectors++;
        if (d0 !== 2'd3 || d2 !== 2'd0) begin
            miscompares++;
            $display("FAIL b2b buffer_kept: got %0d/%0d expected 3/0", d0, d2);
        end
    endtask

    // Reset asserted while COMPUTE is on row 5, then a fresh op after release.
    task automatic test_reset_mid_op();
        logic [DW-1:0] d0, d2;
        int busy_cnt = 0;
        @(negedge clk);
        i_rd_addr = AW'(5);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        while (busy0 && busy_cnt < 5) begin
            busy_cnt++;
            @(negedge clk);
        end
        vectors++;
        if (busy0 !== 1'b1 || data0 !== 2'd3) begin
            miscompares++;
            $display("FAIL rst_mid pre: busy %b data %0d expected 1 3", busy0, data0);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (busy0 !== 1'b0 || data0 !== 2'd0 || done0 !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid async: busy %b data %0d done %b expected 0 0 0", busy0, data0, done0);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done0 !== 1'b0 || busy0 !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("FAIL rst_mid no_done: busy %b done %b expected 0 0", busy0, done0);
            end
        end
        clear_weights();
        prog(3, 5, 1'b1);
        wr_in(3, 2);
        run_op("rst_fresh");
        read_col(5, d0, d2);
        vectors++;
        if (d0 !== 2'd2 || d2 !== 2'd0) begin
            miscompares++;
            $display("FAIL rst_fresh col5: got %0d/%0d expected 2/0", d0, d2);
        end
        read_col(0, d0, d2);
        vectors++;
        if (d0 !== 2'd0 || d2 !== 2'd0) begin
            miscompares++;
            $display("FAIL rst_fresh col0: got %0d/%0d expected 0/0", d0, d2);
        end
    endtask

    initial begin
        test_reset();
        test_saturate_shift();
        test_single_cell();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
